// File: rtl/event_burst_gen.sv
// Event-strobe burst generator: emits burst_len single-cycle strobes spaced gap_len cycles apart.
// Optional macro EVENT_BURST_GEN_REPEAT_EN adds repeat_en for continuous re-bursting until stop.
module event_burst_gen #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef EVENT_BURST_GEN_REPEAT_EN
    input  logic             repeat_en,
`endif
    input  logic [CNT_W-1:0] burst_len,
    input  logic [GAP_W-1:0] gap_len,
    output logic             e_pulse,
    output logic [CNT_W-1:0] pulse_idx,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q, len_nxt;
    logic [CNT_W-1:0] rem_q, rem_nxt;
    logic [CNT_W-1:0] idx_nxt;
    logic [GAP_W-1:0] gap_q, gap_nxt;
    logic [GAP_W-1:0] gcnt_q, gcnt_nxt;
    logic             rep_q, rep_nxt;
    logic             abort_nxt;

    // rem_q counts strobes still to emit, including the one in the current PULSE cycle
    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        gap_nxt   = gap_q;
        rem_nxt   = rem_q;
        gcnt_nxt  = gcnt_q;
        rep_nxt   = rep_q;
        abort_nxt = 1'b0;
        idx_nxt   = pulse_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt = burst_len;
                    gap_nxt = gap_len;
                    rem_nxt = burst_len;
                    idx_nxt = '0;
`ifdef EVENT_BURST_GEN_REPEAT_EN
                    rep_nxt = repeat_en;
`else
                    rep_nxt = 1'b0;
`endif
                    state_nxt = (burst_len == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                if (stop) begin
                    state_nxt = DONE;
                    abort_nxt = 1'b1;
                end else if (rem_q == CNT_W'(1)) begin
                    if (rep_q) begin
                        rem_nxt   = len_q;
                        gcnt_nxt  = gap_q;
                        state_nxt = (gap_q == '0) ? PULSE : GAP;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    rem_nxt   = rem_q - CNT_W'(1);
                    gcnt_nxt  = gap_q;
                    state_nxt = (gap_q == '0) ? PULSE : GAP;
                end
            end
            GAP: begin
                if (stop) begin
                    state_nxt = DONE;
                    abort_nxt = 1'b1;
                end else if (gcnt_q <= GAP_W'(1)) begin
                    state_nxt = PULSE;
                end else begin
                    gcnt_nxt = gcnt_q - GAP_W'(1);
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Index of an upcoming strobe is how many have already gone out in this pass
        if (state_nxt == PULSE) begin
            idx_nxt = len_nxt - rem_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            gap_q     <= '0;
            rem_q     <= '0;
            gcnt_q    <= '0;
            rep_q     <= 1'b0;
            e_pulse   <= 1'b0;
            pulse_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            gap_q     <= gap_nxt;
            rem_q     <= rem_nxt;
            gcnt_q    <= gcnt_nxt;
            rep_q     <= rep_nxt;
            e_pulse   <= (state_nxt == PULSE);
            pulse_idx <= idx_nxt;
            busy      <= (state_nxt == PULSE) || (state_nxt == GAP);
            done      <= (state_nxt == DONE);
            aborted   <= abort_nxt;
            overrun   <= start && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_event_burst_gen.sv
// Directed bench for event_burst_gen; the repeat scenario runs when EVENT_BURST_GEN_REPEAT_EN is defined.
module tb_event_burst_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       repeat_en;
    logic [7:0] burst_len;
    logic [7:0] gap_len;
    logic       e_pulse;
    logic [7:0] pulse_idx;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    event_burst_gen #(.CNT_W(8), .GAP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
`ifdef EVENT_BURST_GEN_REPEAT_EN
        .repeat_en (repeat_en),
`endif
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .e_pulse   (e_pulse),
        .pulse_idx (pulse_idx),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_burst(input logic [7:0] bl, input logic [7:0] gl,
                               input logic rp, input logic st);
        burst_len = bl;
        gap_len   = gl;
        repeat_en = rp;
        start     = 1'b1;
        stop      = st;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [7:0] last_idx;
        rst = 1'b1; start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
        burst_len = 8'd0; gap_len = 8'd0;
        tick();
        tick();
        chk("rst_e_pulse", e_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", pulse_idx, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // burst 3, gap 2: strobes in cycles 1,4,7, done in 8
        begin_burst(8'd3, 8'd2, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            chk("t1_pulse", e_pulse, (k == 1 || k == 4 || k == 7));
            chk("t1_idx", pulse_idx, (k - 1) / 3);
            chk("t1_busy", busy, (k <= 7));
            chk("t1_done", done, (k == 8));
            chk("t1_aborted", aborted, 0);
            tick();
        end

        // burst 4, gap 0 with stop alongside start: stop ignored, back-to-back strobes
        begin_burst(8'd4, 8'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            chk("t2_pulse", e_pulse, (k <= 4));
            chk("t2_idx", pulse_idx, (k <= 4) ? k - 1 : 3);
            chk("t2_done", done, (k == 5));
            chk("t2_aborted", aborted, 0);
            tick();
        end

        // burst 0: immediate done; start during DONE is an overrun
        begin_burst(8'd0, 8'd5, 1'b0, 1'b0);
        chk("t3_done", done, 1);
        chk("t3_aborted", aborted, 0);
        chk("t3_pulse", e_pulse, 0);
        chk("t3_busy", busy, 0);
        chk("t3_idx", pulse_idx, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_overrun", overrun, 1);
        chk("t3_busy2", busy, 0);
        chk("t3_pulse2", e_pulse, 0);
        tick();
        chk("t3_overrun_clr", overrun, 0);

        // burst 5, gap 3: start at edge 3 overruns, stop at edge 6 aborts
        begin_burst(8'd5, 8'd3, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            chk("t4_pulse", e_pulse, (k == 1 || k == 5));
            chk("t4_idx", pulse_idx, (k < 5) ? 0 : 1);
            chk("t4_overrun", overrun, (k == 4));
            chk("t4_done", done, (k == 7));
            chk("t4_aborted", aborted, (k == 7));
            chk("t4_busy", busy, (k <= 6));
            start = (k == 3);
            stop  = (k == 6);
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;

        // asynchronous reset while in GAP
        begin_burst(8'd3, 8'd2, 1'b0, 1'b0);
        tick();
        chk("t5_in_gap", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_pulse", e_pulse, 0);
        chk("t5_async_done", done, 0);
        tick();
        tick();
        chk("t5_hold_done", done, 0);
        chk("t5_hold_busy", busy, 0);
        rst = 1'b0;
        tick();
        begin_burst(8'd1, 8'd0, 1'b0, 1'b0);
        chk("t5_fresh_pulse", e_pulse, 1);
        chk("t5_fresh_idx", pulse_idx, 0);
        tick();
        chk("t5_fresh_done", done, 1);
        chk("t5_fresh_aborted", aborted, 0);
        tick();

        // maximum burst length: 255 strobes, last index 254, no wrap
        begin_burst(8'd255, 8'd0, 1'b0, 1'b0);
        cnt = 0;
        last_idx = 8'd0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (e_pulse) begin
                cnt++;
                last_idx = pulse_idx;
            end
            tick();
        end
        chk("t6_done_seen", done, 1);
        chk("t6_count", cnt, 255);
        chk("t6_last_idx", last_idx, 254);
        tick();

`ifdef EVENT_BURST_GEN_REPEAT_EN
        // repeat: burst 2, gap 1 -> strobes 1,3,5,7 with idx 0,1,0,1; stop in cycle 8
        begin_burst(8'd2, 8'd1, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            chk("t7_pulse", e_pulse, (k <= 7) && (k % 2 == 1));
            if (k <= 7 && (k % 2 == 1)) chk("t7_idx", pulse_idx, ((k - 1) / 2) % 2);
            chk("t7_done", done, (k == 9));
            chk("t7_aborted", aborted, (k == 9));
            stop = (k == 8);
            tick();
        end
        stop = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
